// File: rtl/ringy_measure_ctrl.sv
// Ring-oscillator measurement sequencer: selects one ring, lets it settle, counts its
// synchronised rising edges over a 2**GATE_LOG2-cycle window and holds the result until acked.
module ringy_measure_ctrl #(
  parameter int N_RINGS    = 4,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 16,
  parameter int GATE_LOG2  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic               scan,
  input  logic [SEL_W-1:0]   ring_sel,
  input  logic [N_RINGS-1:0] ring_in,
  output logic [N_RINGS-1:0] ring_en,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ack,
  output logic [CNT_W-1:0]   res_data,
  output logic [SEL_W-1:0]   res_ring,
  output logic               overflow,
  output logic               sel_err
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (GATE_LOG2 + 1 > SET_W) ? GATE_LOG2 + 1 : SET_W;
  localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0]   GATE_LAST   = TMR_W'((1 << GATE_LOG2) - 1);
  localparam logic [N_RINGS-1:0] ONE_HOT0    = N_RINGS'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               scan_q, scan_d;
  logic               sel_err_d;
  logic               tmr_last;
  logic [TMR_W-1:0]   tmr_q;
  logic [N_RINGS-1:0] ring_p0, ring_p1, ring_p2;
  logic [N_RINGS-1:0] idx_hot;
  logic               edge_hit;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic [CNT_W:0]     acc_nxt;

  // Saturating edge accumulate; returns {sticky_overflow, count}.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c,
                                             input logic o, input logic e);
    if (!e)
      return {o, c};
    if (&c)
      return {1'b1, c};
    return {o, c + CNT_W'(1)};
  endfunction

  assign idx_hot  = ONE_HOT0 << idx_q;
  assign edge_hit = |(ring_p1 & ~ring_p2 & idx_hot);
  assign acc_nxt  = sat_inc(cnt_q, ovf_q, edge_hit);
  assign tmr_last = ((state_q == SETTLE) && (tmr_q == SETTLE_LAST)) ||
                    ((state_q == GATE)   && (tmr_q == GATE_LAST));

  assign ring_en   = (ena && ((state_q == SETTLE) || (state_q == GATE))) ? idx_hot : '0;
  assign busy      = (state_q != IDLE);
  assign res_valid = ena && (state_q == HOLD);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    scan_d    = scan_q;
    sel_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && ena) begin
          if (scan) begin
            state_d = SETTLE;
            idx_d   = '0;
            scan_d  = 1'b1;
          end else if (32'(ring_sel) < N_RINGS) begin
            state_d = SETTLE;
            idx_d   = ring_sel;
            scan_d  = 1'b0;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      SETTLE: if (tmr_last) state_d = GATE;
      GATE:   if (tmr_last) state_d = HOLD;
      HOLD: begin
        if (res_ack) begin
          if (scan_q && (32'(idx_q) < N_RINGS - 1)) begin
            state_d = SETTLE;
            idx_d   = idx_q + SEL_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!ena)
      state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      scan_q   <= 1'b0;
      tmr_q    <= '0;
      sel_err  <= 1'b0;
      ring_p0  <= '0;
      ring_p1  <= '0;
      ring_p2  <= '0;
      res_data <= '0;
      res_ring <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      scan_q  <= scan_d;
      sel_err <= sel_err_d;
      if ((state_d != state_q) || !((state_q == SETTLE) || (state_q == GATE)))
        tmr_q <= '0;
      else
        tmr_q <= tmr_q + TMR_W'(1);
      // p0/p1: two-flop synchroniser; p2: previous sample for rising-edge detect
      ring_p0 <= ring_in;
      ring_p1 <= ring_p0;
      ring_p2 <= ring_p1;
      if ((state_q == GATE) && tmr_last && ena) begin
        res_data <= acc_nxt[CNT_W-1:0];
        overflow <= acc_nxt[CNT_W];
        res_ring <= idx_q;
      end
    end
  end

  // Accumulator is cleared on GATE entry, so it needs no reset of its own.
  always_ff @(posedge clk) begin
    if ((state_q == SETTLE) && (state_d == GATE)) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (state_q == GATE) begin
      cnt_q <= acc_nxt[CNT_W-1:0];
      ovf_q <= acc_nxt[CNT_W];
    end
  end

endmodule

// File: tb/tb_ringy_measure_ctrl.sv
// Bench for ringy_measure_ctrl: square-wave rings with chosen half-periods, expected counts
// derived from window length / ring period, plus timing, backpressure, abort and select checks.
module tb_ringy_measure_ctrl;

  localparam int WIN = 1024;

  logic clk = 1'b0;
  logic rst_n, ena, res_ack;
  logic [3:0] ring_in;

  logic start, scan;
  logic [1:0] ring_sel;
  logic [3:0] ring_en;
  logic busy, res_valid, overflow, sel_err;
  logic [15:0] res_data;
  logic [1:0] res_ring;

  logic b_start, b_scan;
  logic [1:0] b_sel;
  logic [2:0] b_ring_en;
  logic b_busy, b_res_valid, b_overflow, b_sel_err;
  logic [7:0] b_res_data;
  logic [1:0] b_res_ring;

  int checks = 0;
  int errors = 0;
  int half [4];
  int cnt_r [4];

  ringy_measure_ctrl #(.N_RINGS(4), .SEL_W(2), .CNT_W(16), .SETTLE_CYC(16), .GATE_LOG2(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .scan(scan), .ring_sel(ring_sel),
    .ring_in(ring_in), .ring_en(ring_en), .busy(busy), .res_valid(res_valid), .res_ack(res_ack),
    .res_data(res_data), .res_ring(res_ring), .overflow(overflow), .sel_err(sel_err));

  ringy_measure_ctrl #(.N_RINGS(3), .SEL_W(2), .CNT_W(8), .SETTLE_CYC(16), .GATE_LOG2(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(b_start), .scan(b_scan), .ring_sel(b_sel),
    .ring_in(ring_in[2:0]), .ring_en(b_ring_en), .busy(b_busy), .res_valid(b_res_valid),
    .res_ack(res_ack), .res_data(b_res_data), .res_ring(b_res_ring), .overflow(b_overflow),
    .sel_err(b_sel_err));

  always #5 clk = ~clk;

  // Square-wave rings: each toggles every half[i] clocks, changing on the falling edge.
  initial begin
    ring_in = '0;
    for (int i = 0; i < 4; i++) begin
      half[i]  = 3;
      cnt_r[i] = 1;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] = cnt_r[i] - 1;
        if (cnt_r[i] <= 0) begin
          ring_in[i] = ~ring_in[i];
          cnt_r[i]   = half[i];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a ring of period p yields floor or ceil of win/p rising edges in the window.
  function automatic int exp_lo(int p);
    return WIN / p;
  endfunction
  function automatic int exp_hi(int p);
    return (WIN + p - 1) / p;
  endfunction

  task automatic set_halves(input int h0, input int h1, input int h2, input int h3);
    half[0] = h0; half[1] = h1; half[2] = h2; half[3] = h3;
    repeat (70) tick();
  endtask

  // Runs one non-scan measurement on dut_a up to the first HOLD cycle, returning observations.
  task automatic run_a(input logic [1:0] s, output logic [3:0] en_first,
                       output logic vld_early, output logic vld_on, output int onehot_bad);
    onehot_bad = 0;
    ring_sel = s; scan = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    en_first = ring_en;
    for (int i = 0; i < 1039; i++) begin
      if ($countones(ring_en) > 1) onehot_bad++;
      tick();
    end
    vld_early = res_valid;
    tick();
    vld_on = res_valid;
  endtask

  task automatic run_b(input logic [1:0] s, output logic vld_on);
    b_sel = s; b_scan = 1'b0; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    repeat (1040) tick();
    vld_on = b_res_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0;
    repeat (2) tick();
    checks++; if (ring_en !== 4'b0) begin errors++; $display("FAIL reset_ring_en got %b want 0", ring_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (res_data !== 16'd0) begin errors++; $display("FAIL reset_res_data got %0d want 0", res_data); end
    checks++; if (res_ring !== 2'd0) begin errors++; $display("FAIL reset_res_ring got %0d want 0", res_ring); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %b want 0", sel_err); end
    checks++; if ({b_busy, b_res_valid, b_ring_en} !== 5'b0) begin errors++; $display("FAIL reset_b_outputs got %b want 0", {b_busy, b_res_valid, b_ring_en}); end
    rst_n = 1'b1; ena = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    logic [3:0] en_first;
    logic vld_early, vld_on;
    int bad;
    set_halves(3, 5, 4, 7);
    run_a(2'd2, en_first, vld_early, vld_on, bad);
    checks++; if (en_first !== 4'b0100) begin errors++; $display("FAIL single_ring_en got %b want 0100", en_first); end
    checks++; if (vld_early !== 1'b0) begin errors++; $display("FAIL single_valid_early got %b want 0", vld_early); end
    checks++; if (vld_on !== 1'b1) begin errors++; $display("FAIL single_valid_latency got %b want 1", vld_on); end
    checks++; if (res_data < 16'(exp_lo(8)) || res_data > 16'(exp_hi(8))) begin errors++; $display("FAIL single_data got %0d want %0d", res_data, exp_lo(8)); end
    checks++; if (res_ring !== 2'd2) begin errors++; $display("FAIL single_res_ring got %0d want 2", res_ring); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL single_overflow got %b want 0", overflow); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL single_onehot got %0d bad cycles want 0", bad); end
    checks++; if (ring_en !== 4'b0) begin errors++; $display("FAIL single_hold_ring_en got %b want 0", ring_en); end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_ack_drop got %b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_ack_idle got %b want 0", busy); end
  endtask

  task automatic test_random_single();
    logic [3:0] en_first;
    logic vld_early, vld_on;
    int bad, p;
    logic [1:0] s;
    for (int it = 0; it < 4; it++) begin
      set_halves($urandom_range(2, 24), $urandom_range(2, 24), $urandom_range(2, 24), $urandom_range(2, 24));
      s = 2'($urandom_range(0, 3));
      p = 2 * half[s];
      run_a(s, en_first, vld_early, vld_on, bad);
      checks++; if (en_first !== (4'b0001 << s)) begin errors++; $display("FAIL rand_ring_en got %b sel %0d", en_first, s); end
      checks++; if (vld_on !== 1'b1 || vld_early !== 1'b0) begin errors++; $display("FAIL rand_latency got %b%b want 01", vld_early, vld_on); end
      checks++; if (res_data < 16'(exp_lo(p)) || res_data > 16'(exp_hi(p))) begin errors++; $display("FAIL rand_data got %0d want %0d..%0d", res_data, exp_lo(p), exp_hi(p)); end
      checks++; if (res_ring !== s || overflow !== 1'b0) begin errors++; $display("FAIL rand_ring_ovf got %0d/%b want %0d/0", res_ring, overflow, s); end
      res_ack = 1'b1;
      tick();
      res_ack = 1'b0;
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rand_ack got %b%b want 00", res_valid, busy); end
    end
  endtask

  task automatic test_scan();
    int n;
    int p;
    set_halves(4, 8, 16, 32);
    scan = 1'b1; ring_sel = 2'd3; start = 1'b1;
    tick();
    start = 1'b0; scan = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (res_valid !== 1'b1 && n < 1200) begin tick(); n++; end
      checks++; if (n >= 1200) begin errors++; $display("FAIL scan_timeout ring %0d got no res_valid", k); end
      p = 8 << k;
      checks++; if (res_ring !== 2'(k)) begin errors++; $display("FAIL scan_order got %0d want %0d", res_ring, k); end
      checks++; if (res_data < 16'(exp_lo(p)) || res_data > 16'(exp_hi(p))) begin errors++; $display("FAIL scan_data ring %0d got %0d want %0d", k, res_data, WIN / p); end
      repeat ($urandom_range(0, 5)) tick();
      res_ack = 1'b1;
      tick();
      res_ack = 1'b0;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL scan_ack_drop got %b want 0", res_valid); end
      if (k < 3) begin
        checks++; if (ring_en !== (4'b0001 << (k + 1))) begin errors++; $display("FAIL scan_next_en got %b want ring %0d", ring_en, k + 1); end
      end else begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL scan_end_busy got %b want 0", busy); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] en_first;
    logic vld_early, vld_on;
    int bad, unstable;
    logic [15:0] held;
    set_halves(6, 5, 9, 11);
    run_a(2'd1, en_first, vld_early, vld_on, bad);
    held = res_data;
    unstable = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 40) begin ring_sel = 2'd3; start = 1'b1; end
      if (i == 41) start = 1'b0;
      if (res_valid !== 1'b1 || res_data !== held || ring_en !== 4'b0 || res_ring !== 2'd1) unstable++;
      tick();
    end
    checks++; if (vld_on !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", vld_on); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles want 0", unstable); end
    checks++; if (held < 16'(exp_lo(10)) || held > 16'(exp_hi(10))) begin errors++; $display("FAIL bp_data got %0d want %0d", held, WIN / 10); end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_ack got %b%b want 00", res_valid, busy); end
  endtask

  task automatic test_abort();
    int seen;
    ring_sel = 2'd3; scan = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16 + 300) tick();
    checks++; if (ring_en !== 4'b1000) begin errors++; $display("FAIL abort_gate_en got %b want 1000", ring_en); end
    ena = 1'b0;
    #1;
    checks++; if (ring_en !== 4'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL abort_same_cycle got %b/%b want 0000/0", ring_en, res_valid); end
    tick();
    ena = 1'b1;
    checks++; if (busy !== 1'b0 || ring_en !== 4'b0) begin errors++; $display("FAIL abort_idle got %b/%b want 0/0000", busy, ring_en); end
    seen = 0;
    for (int i = 0; i < 1100; i++) begin
      if (res_valid === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_result got %0d active cycles want 0", seen); end
    ring_sel = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++; if (ring_en !== 4'b0100) begin errors++; $display("FAIL rst_pre_en got %b want 0100", ring_en); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if ({ring_en, busy, res_valid, overflow, sel_err} !== 8'b0) begin errors++; $display("FAIL rst_async_ctrl got %b want 0", {ring_en, busy, res_valid, overflow, sel_err}); end
    checks++; if (res_data !== 16'd0 || res_ring !== 2'd0) begin errors++; $display("FAIL rst_async_data got %0d/%0d want 0/0", res_data, res_ring); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_overflow();
    logic vld_on;
    set_halves(4, 1, 5, 5);
    run_b(2'd1, vld_on);
    checks++; if (vld_on !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", vld_on); end
    checks++; if (b_res_data !== 8'd255 || b_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sat got %0d/%b want 255/1", b_res_data, b_overflow); end
    res_ack = 1'b1; tick(); res_ack = 1'b0;
    run_b(2'd0, vld_on);
    checks++; if (b_res_data < 8'(exp_lo(8)) || b_res_data > 8'(exp_hi(8)) || b_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0d/%b want 128/0", b_res_data, b_overflow); end
    checks++; if (b_res_ring !== 2'd0) begin errors++; $display("FAIL ovf_ring got %0d want 0", b_res_ring); end
    res_ack = 1'b1; tick(); res_ack = 1'b0;
    checks++; if (b_res_valid !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL ovf_ack got %b%b want 00", b_res_valid, b_busy); end
  endtask

  task automatic test_bad_sel();
    b_sel = 2'd3; b_scan = 1'b0; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    checks++; if (b_sel_err !== 1'b1) begin errors++; $display("FAIL badsel_pulse got %b want 1", b_sel_err); end
    checks++; if (b_busy !== 1'b0 || b_ring_en !== 3'b0) begin errors++; $display("FAIL badsel_idle got %b/%b want 0/000", b_busy, b_ring_en); end
    tick();
    checks++; if (b_sel_err !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL badsel_width got %b/%b want 0/0", b_sel_err, b_busy); end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; res_ack = 1'b0;
    start = 1'b0; scan = 1'b0; ring_sel = 2'd0;
    b_start = 1'b0; b_scan = 1'b0; b_sel = 2'd0;
    test_reset();
    test_single();
    test_random_single();
    test_scan();
    test_backpressure();
    test_abort();
    test_overflow();
    test_bad_sel();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
